// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared definitions for the seven-segment scan controller.
//   SEG_W        segment bus width (a..g)
//   SEG_OFF      active-low "all segments dark" pattern
//   MAX_DIGITS   widest display the controller is built for
//   an_all_off() all-anodes-off pattern, sliced to width by the user
//   digit_t      per-digit record {nibble, blank, dp}, used for staging and shadow
package seg_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    typedef struct packed {
        logic [3:0] nibble;
        logic       blank;
        logic       dp;
    } digit_t;

    // Anodes are active-low, so "everything off" is all ones.
    function automatic logic [MAX_DIGITS-1:0] an_all_off();
        return '1;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_if: application-side bus plus display pins of seg_scan_ctrl.
//   value_in / blank_in / dp_in  display data captured on load
//   load                          one-cycle capture strobe
//   load_ack                      one-cycle pulse when the capture is committed
//   frame_start                   one-cycle pulse at the start of digit 0's slot
//   an / seg / dp                 active-low anode, segment and decimal-point pins
// master: the application datapath. slave: the scan controller.
interface seg_scan_if
    import seg_pkg::*;
#(
    parameter int DIGITS = 4
);

    logic [4*DIGITS-1:0] value_in;
    logic [DIGITS-1:0]   blank_in;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                load_ack;
    logic                frame_start;
    logic [DIGITS-1:0]   an;
    logic [SEG_W-1:0]    seg;
    logic                dp;

    modport master (
        output value_in, blank_in, dp_in, load,
        input  load_ack, frame_start, an, seg, dp
    );

    modport slave (
        input  value_in, blank_in, dp_in, load,
        output load_ack, frame_start, an, seg, dp
    );

endinterface

// File: rtl/seg_scan_ctrl_hex7seg.sv
// hex7seg: hex digit to active-low seven-segment pattern (seg_n[0] = a).
//   code   [4:0]  bit 4 set means "no glyph", bits 3:0 are the hex digit
//   seg_n  [6:0]  active-low segments a..g
module hex7seg
    import seg_pkg::*;
(
    input  logic [4:0]       code,
    output logic [SEG_W-1:0] seg_n
);

    // Plain lookup; codes with bit 4 set leave every segment dark.
    always_comb begin
        seg_n = SEG_OFF;
        if (!code[4]) begin
            case (code[3:0])
                4'h0:    seg_n = 7'h40;
                4'h1:    seg_n = 7'h79;
                4'h2:    seg_n = 7'h24;
                4'h3:    seg_n = 7'h30;
                4'h4:    seg_n = 7'h19;
                4'h5:    seg_n = 7'h12;
                4'h6:    seg_n = 7'h02;
                4'h7:    seg_n = 7'h78;
                4'h8:    seg_n = 7'h00;
                4'h9:    seg_n = 7'h10;
                4'hA:    seg_n = 7'h08;
                4'hB:    seg_n = 7'h03;
                4'hC:    seg_n = 7'h46;
                4'hD:    seg_n = 7'h21;
                4'hE:    seg_n = 7'h06;
                default: seg_n = 7'h0E;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// seven-segment display. One digit per dwell slot, anodes off for the first
// GAP_CYCLES of each slot, new values double-buffered and committed only at
// frame boundaries.
//   clk, rst  clock and synchronous active-high reset
//   bus       seg_scan_if.slave (data/load in, load_ack/frame_start/an/seg/dp out)
// Optional feature macro: SEG_SCAN_LEADZ_BLANK_EN -- when defined, leading
// zero digits (never digit 0) are auto-blanked at commit.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SLOT_CYCLES = 100000,
    parameter int GAP_CYCLES  = 2000
)(
    input  logic     clk,
    input  logic     rst,
    seg_scan_if.slave bus
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]         SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0]         GAP_C     = CW'(GAP_CYCLES);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [MAX_DIGITS-1:0] AN_OFF_W  = an_all_off();
    localparam logic [DIGITS-1:0]     AN_OFF    = AN_OFF_W[DIGITS-1:0];

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic              pending;
    digit_t            staging    [DIGITS];
    digit_t            shadow     [DIGITS];
    digit_t            commit_val [DIGITS];

    logic              slot_end;
    logic              boundary;
    logic              in_gap;
    digit_t            cur;
    logic [SEG_W-1:0]  dec_seg;
    logic [DIGITS-1:0] an_next;
    logic [SEG_W-1:0]  seg_next;
    logic              dp_next;

`ifdef SEG_SCAN_LEADZ_BLANK_EN
    logic              lead;
`endif

    // Single shared decoder, always pointed at the digit currently scanned.
    hex7seg u_hex7seg (
        .code  ({1'b0, cur.nibble}),
        .seg_n (dec_seg)
    );

    // Scan-position decode and the pin values for the current position.
    // During the guard interval everything is dark; a blanked digit keeps its
    // anode off but still shows its decimal point setting on dp.
    always_comb begin
        slot_end = (cnt == SLOT_LAST);
        boundary = slot_end && (idx == IDX_LAST);
        in_gap   = (cnt < GAP_C);
        cur      = shadow[idx];
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        if (!in_gap) begin
            dp_next = ~cur.dp;
            if (!cur.blank) begin
                an_next[idx] = 1'b0;
                seg_next     = dec_seg;
            end
        end
    end

    // Value that gets copied into the shadow at a commit. With leading-zero
    // blanking enabled, zeros from the top digit downward are forced dark until
    // the first non-zero digit; digit 0 is left alone so "0" still displays.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            commit_val[i] = staging[i];
        end
`ifdef SEG_SCAN_LEADZ_BLANK_EN
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead = lead && (staging[i].nibble == 4'h0);
            if (lead) begin
                commit_val[i].blank = 1'b1;
            end
        end
`endif
    end

    // Scan counters, double buffer and registered outputs. The commit reads the
    // old staging content, so a load landing on the boundary cycle is kept in
    // staging with pending still set and goes out one frame later.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            idx             <= '0;
            pending         <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                staging[i] <= '0;
                shadow[i]  <= '0;
            end
            bus.an          <= AN_OFF;
            bus.seg         <= SEG_OFF;
            bus.dp          <= 1'b1;
            bus.load_ack    <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end

            bus.load_ack <= boundary && pending;
            if (boundary && pending) begin
                for (int i = 0; i < DIGITS; i++) begin
                    shadow[i] <= commit_val[i];
                end
                pending <= 1'b0;
            end

            if (bus.load) begin
                pending <= 1'b1;
                for (int i = 0; i < DIGITS; i++) begin
                    staging[i] <= {bus.value_in[4*i +: 4], bus.blank_in[i], bus.dp_in[i]};
                end
            end

            bus.an          <= an_next;
            bus.seg         <= seg_next;
            bus.dp          <= dp_next;
            bus.frame_start <= (cnt == '0) && (idx == '0);
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's four-digit common-anode seven-segment display. It sequences one shared hex-to-segment decoder across all digits, one digit per dwell slot, with an anode-off guard interval at the start of each slot to prevent ghosting. New display values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the application datapath and the top-level anode, segment and decimal-point pins.

## Interface
- DIGITS, 4, number of multiplexed digits (2..8)
- SLOT_CYCLES, 100000, clock cycles each digit owns per frame (≥ GAP_CYCLES+2)
- GAP_CYCLES, 2000, cycles at the start of each slot with all anodes off (≥1)

- clk  in  1  system clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- value_in  in  4*DIGITS  hex nibbles; digit i = value_in[4i+3:4i]
- blank_in  in  DIGITS  1 = force digit i dark
- dp_in  in  DIGITS  1 = light decimal point of digit i
- load  in  1  one-cycle strobe: capture value_in/blank_in/dp_in into staging
- load_ack  out  1  one-cycle pulse when staging is committed to display
- frame_start  out  1  one-cycle pulse at the start of digit 0's slot
- an  out  DIGITS  anodes, active-low
- seg  out  7  segments a..g (seg[0]=a), active-low
- dp  out  1  decimal point, active-low

## Operation
- Slot counter cnt runs 0..SLOT_CYCLES-1 and then wraps. On each wrap, digit index idx advances, with DIGITS-1 wrapping to 0.
- Frame boundary: the cycle on which cnt wraps while idx = DIGITS-1.
- Guard interval: while cnt < GAP_CYCLES, an is all ones. Otherwise an[idx]=0 unless the shadow blank bit for idx is set.
- Segments come from one hex7seg instance fed {1'b0, shadow nibble[idx]}. Only its outputs [6:0] are used; seg is forced to 7'h7F during the guard interval or when the digit is blanked.
- dp = ~shadow_dp[idx] outside the guard interval and 1 otherwise.
- Load handshake:
  - load sets pending and overwrites staging. If load repeats while pending, the latest capture wins.
  - At a frame boundary with pending set: shadow <= staging, pending clears, and load_ack pulses on the next cycle.
  - If load and a frame boundary coincide: the old staging content is committed. The new capture is written to staging, pending stays set, and the new value commits at the following boundary.
- Reset mid-frame abandons the frame and the pending load. Scan restarts at idx=0, cnt=0.

## Timing
- Reset values: an = all ones, seg = 7'h7F, dp = 1, load_ack = 0, frame_start = 0, idx = 0, cnt = 0, shadow/staging/pending = 0.
- All outputs are registered. an, seg and dp reflect the cnt/idx state with a one-cycle latency.
- frame_start is asserted in the cycle after cnt wraps into idx=0, and in the first cycle after reset release.
- Worst-case load-to-display latency: DIGITS*SLOT_CYCLES + 2 cycles.
- Frame period: DIGITS*SLOT_CYCLES cycles exactly. No dwell slot is stretched or skipped.

## Configuration
- SEG_SCAN_LEADZ_BLANK_EN defined: at commit, leading zero digits (MSB downward, up to but excluding digit 0) get their shadow blank bit set in addition to blank_in. Digit 0 is never auto-blanked.
- Not defined: only blank_in controls blanking. Zero digits display "0".

## Structure
- Shared package seg_pkg holds:
  - segment constant SEG_OFF = 7'h7F
  - anode-off constant helper
  - the digit-record typedef {nibble[3:0], blank, dp}, used for both the staging and shadow arrays
- One sub-module: the existing hex7seg, instantiated once and shared across digits. The scan counter and load logic stay inline.

## Test plan
Test parameters: DIGITS=4, SLOT_CYCLES=8, GAP_CYCLES=2.
- Reset: hold rst 3 cycles → an=4'hF, seg=7'h7F, dp=1. After release, first frame_start, then an=4'b1110 from cycle 3.
- Scan order: load 16'h4321, wait one frame → an visits 1110,1101,1011,0111 for 6 cycles each, separated by 2-cycle 4'hF gaps. seg at each digit = decode(1), (2), (3), (4).
- Tear-free commit: load 16'hABCD mid-frame → display unchanged until the boundary. load_ack pulses once, and the next frame shows D,C,B,A.
- Coincident load: load 16'h1111, then assert load with 16'h2222 exactly on the frame boundary → the next frame shows 1111, the one after shows 2222. load_ack pulses twice.
- Blank/dp: blank_in=4'b0100, dp_in=4'b0001 → digit 2 anode never low, dp low only during digit 0's active window.
- Macro on: load 16'h0050 → digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0. Load 16'h0000 → only digit 0 lit, showing 0.
